turn_controller: RTL

Sequences one two-player match of the nine-card game. Accepts each player's card confirmation and rejects invalid choices. Drives the per-player handout datapath (card-select vector plus a one-clock handout pulse), compares the two handed-out card values each round, and keeps score over nine rounds. Sits between the player input logic and the two handout instances (p1, p2).

---
 rtl/turn_controller.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/turn_controller.sv
// turn_controller: sequences one two-player, nine-round card match.
// It validates each player's card confirmation, drives the per-player
// handout datapath (card-select vector plus a one-clock handout pulse),
// compares the handed-out card values and keeps score.
module turn_controller #(
    parameter int NUM_ROUNDS = 9,
    parameter int SCORE_W    = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [8:0]         p1_select,
    input  logic               p1_confirm,
    input  logic [8:0]         p2_select,
    input  logic               p2_confirm,
    input  logic [8:0]         p1_used,
    input  logic [8:0]         p2_used,
    input  logic [3:0]         p1_handcard,
    input  logic [3:0]         p2_handcard,
    output logic [8:0]         p1_cardselect,
    output logic [8:0]         p2_cardselect,
    output logic               p1_handout_pulse,
    output logic               p2_handout_pulse,
    output logic               card_clear,
    output logic [1:0]         active_player,
    output logic [3:0]         round,
    output logic [SCORE_W-1:0] p1_score,
    output logic [SCORE_W-1:0] p2_score,
    output logic               sel_error,
    output logic               game_over,
    output logic [1:0]         winner
);

    typedef enum logic [2:0] {
        IDLE,
        LEAD_WAIT,
        LEAD_PULSE,
        FOLLOW_WAIT,
        FOLLOW_PULSE,
        COMPARE,
        DONE
    } state_t;

    localparam logic [3:0]         ROUND_LAST = 4'(NUM_ROUNDS);
    localparam logic [3:0]         ROUND_ONE  = 4'd1;
    localparam logic [SCORE_W-1:0] SCORE_ONE  = SCORE_W'(1);

    state_t             state_q, state_d;
    logic               lead_p1_q, lead_p1_d;
    logic [8:0]         p1_cs_q, p1_cs_d;
    logic [8:0]         p2_cs_q, p2_cs_d;
    logic               p1_pulse_q, p1_pulse_d;
    logic               p2_pulse_q, p2_pulse_d;
    logic               clear_q, clear_d;
    logic [3:0]         round_q, round_d;
    logic [SCORE_W-1:0] p1_score_q, p1_score_d;
    logic [SCORE_W-1:0] p2_score_q, p2_score_d;
    logic               sel_err_q, sel_err_d;
    logic               game_over_q, game_over_d;
    logic [1:0]         winner_q, winner_d;

    logic               act_is_p1;
    logic               act_confirm;
    logic [8:0]         act_sel;
    logic [8:0]         act_used;
    logic               sel_valid;

    // State and output registers; reset drops any pulse in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            lead_p1_q   <= 1'b1;
            p1_cs_q     <= '0;
            p2_cs_q     <= '0;
            p1_pulse_q  <= 1'b0;
            p2_pulse_q  <= 1'b0;
            clear_q     <= 1'b0;
            round_q     <= '0;
            p1_score_q  <= '0;
            p2_score_q  <= '0;
            sel_err_q   <= 1'b0;
            game_over_q <= 1'b0;
            winner_q    <= '0;
        end else begin
            state_q     <= state_d;
            lead_p1_q   <= lead_p1_d;
            p1_cs_q     <= p1_cs_d;
            p2_cs_q     <= p2_cs_d;
            p1_pulse_q  <= p1_pulse_d;
            p2_pulse_q  <= p2_pulse_d;
            clear_q     <= clear_d;
            round_q     <= round_d;
            p1_score_q  <= p1_score_d;
            p2_score_q  <= p2_score_d;
            sel_err_q   <= sel_err_d;
            game_over_q <= game_over_d;
            winner_q    <= winner_d;
        end
    end

    // Next-state and next-output decode for the match sequencer.
    always_comb begin
        state_d     = state_q;
        lead_p1_d   = lead_p1_q;
        p1_cs_d     = p1_cs_q;
        p2_cs_d     = p2_cs_q;
        p1_pulse_d  = 1'b0;
        p2_pulse_d  = 1'b0;
        clear_d     = 1'b0;
        round_d     = round_q;
        p1_score_d  = p1_score_q;
        p2_score_d  = p2_score_q;
        sel_err_d   = 1'b0;
        game_over_d = game_over_q;
        winner_d    = winner_q;

        act_is_p1   = (state_q == LEAD_WAIT) ? lead_p1_q : !lead_p1_q;
        act_confirm = act_is_p1 ? p1_confirm : p2_confirm;
        act_sel     = act_is_p1 ? p1_select  : p2_select;
        act_used    = act_is_p1 ? p1_used    : p2_used;
        sel_valid   = (act_sel != '0) && ((act_sel & (act_sel - 9'd1)) == '0)
                      && ((act_sel & act_used) == '0);

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d     = LEAD_WAIT;
                    clear_d     = 1'b1;
                    round_d     = '0;
                    p1_score_d  = '0;
                    p2_score_d  = '0;
                    game_over_d = 1'b0;
                    winner_d    = '0;
                    lead_p1_d   = 1'b1;
                end
            end
            LEAD_WAIT, FOLLOW_WAIT: begin
                if (act_confirm) begin
                    if (sel_valid) begin
                        state_d = (state_q == LEAD_WAIT) ? LEAD_PULSE : FOLLOW_PULSE;
                        if (act_is_p1) begin
                            p1_cs_d    = act_sel;
                            p1_pulse_d = 1'b1;
                        end else begin
                            p2_cs_d    = act_sel;
                            p2_pulse_d = 1'b1;
                        end
                    end else begin
                        sel_err_d = 1'b1;
                    end
                end
            end
            LEAD_PULSE: begin
                state_d = FOLLOW_WAIT;
            end
            FOLLOW_PULSE: begin
                state_d = COMPARE;
            end
            COMPARE: begin
                if (p1_handcard > p2_handcard) begin
                    if (p1_score_q != '1) p1_score_d = p1_score_q + SCORE_ONE;
                end else if (p2_handcard > p1_handcard) begin
                    if (p2_score_q != '1) p2_score_d = p2_score_q + SCORE_ONE;
                end
                round_d   = round_q + ROUND_ONE;
                lead_p1_d = !lead_p1_q;
                if (round_d == ROUND_LAST) begin
                    state_d     = DONE;
                    game_over_d = 1'b1;
                    if (p1_score_d > p2_score_d)      winner_d = 2'b01;
                    else if (p1_score_d < p2_score_d) winner_d = 2'b10;
                    else                              winner_d = 2'b11;
                end else begin
                    state_d = LEAD_WAIT;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Active-player indicator decoded from the waiting states.
    always_comb begin
        active_player = 2'b00;
        if (state_q == LEAD_WAIT)        active_player = lead_p1_q ? 2'b01 : 2'b10;
        else if (state_q == FOLLOW_WAIT) active_player = lead_p1_q ? 2'b10 : 2'b01;
    end

    assign p1_cardselect    = p1_cs_q;
    assign p2_cardselect    = p2_cs_q;
    assign p1_handout_pulse = p1_pulse_q;
    assign p2_handout_pulse = p2_pulse_q;
    assign card_clear       = clear_q;
    assign round            = round_q;
    assign p1_score         = p1_score_q;
    assign p2_score         = p2_score_q;
    assign sel_error        = sel_err_q;
    assign game_over        = game_over_q;
    assign winner           = winner_q;

endmodule
